// File: rtl/demux_1_4_buf.sv
// 1-to-4 demultiplexer with an independent 2-entry FIFO on each output lane.
// Define DEMUX_1_4_BUF_CNT_EN to add 16-bit per-lane output-transfer counters (cnt0..cnt3).
module demux_1_4_buf #(
  parameter int data_width_param = 32,
  parameter int sel_width_param  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [data_width_param-1:0] din,
  input  logic [sel_width_param-1:0]  sel,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [data_width_param-1:0] q0,
  output logic [data_width_param-1:0] q1,
  output logic [data_width_param-1:0] q2,
  output logic [data_width_param-1:0] q3,
  output logic [3:0]                  q_valid,
  input  logic [3:0]                  q_ready
`ifdef DEMUX_1_4_BUF_CNT_EN
  ,
  output logic [15:0]                 cnt0,
  output logic [15:0]                 cnt1,
  output logic [15:0]                 cnt2,
  output logic [15:0]                 cnt3
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_t;

  lane_state_t                 state      [4];
  lane_state_t                 state_next [4];
  logic [data_width_param-1:0] mem        [4][2];
  logic [data_width_param-1:0] head       [4];
  logic [data_width_param-1:0] head_next  [4];
  logic                        wr_ptr     [4];
  logic                        rd_ptr     [4];
  logic [3:0]                  push;
  logic [3:0]                  pop;

  // A full lane still accepts a word when its head leaves in the same cycle.
  assign din_ready = (state[sel] != FULL) || q_ready[sel];
  assign push      = (din_valid && din_ready) ? (4'b0001 << sel) : 4'b0000;
  assign pop       = q_valid & q_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q_valid[i] = (state[i] != EMPTY);
    end
  end

  // The head is kept in its own register so it holds its last value while the
  // lane is empty, independent of which slot the read pointer has moved to.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_next[i] = state[i];
      head_next[i]  = head[i];
      case (state[i])
        EMPTY: begin
          if (push[i]) begin
            state_next[i] = ONE;
            head_next[i]  = din;
          end
        end
        ONE: begin
          if (push[i]) begin
            head_next[i] = pop[i] ? din : head[i];
            if (!pop[i]) state_next[i] = FULL;
          end else if (pop[i]) begin
            state_next[i] = EMPTY;
          end
        end
        FULL: begin
          if (pop[i]) begin
            head_next[i] = mem[i][~rd_ptr[i]];
            if (!push[i]) state_next[i] = ONE;
          end
        end
        default: state_next[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
        state[i]  <= EMPTY;
        head[i]   <= '0;
        wr_ptr[i] <= 1'b0;
        rd_ptr[i] <= 1'b0;
      end else begin
        state[i] <= state_next[i];
        head[i]  <= head_next[i];
        if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
      end
    end
  end

  // NOTE: the storage array has no reset; the lane state and pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n && push[i]) mem[i][wr_ptr[i]] <= din;
    end
  end

  assign q0 = head[0];
  assign q1 = head[1];
  assign q2 = head[2];
  assign q3 = head[3];

`ifdef DEMUX_1_4_BUF_CNT_EN
  logic [15:0] cnt [4];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n)      cnt[i] <= 16'd0;
      else if (pop[i]) cnt[i] <= cnt[i] + 16'd1;
    end
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
`endif

endmodule
